fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register.
- Holds the PC and issues requests to the instruction memory.
- Buffers one response under stall and handles branch/jump redirects.
- Presents the registered instruction fields (opcode, rs, rt, rd, imm) to the decode/control stage. An empty slot is presented as an all-zero instruction, so decode sees a harmless R-format word with rd=0.

Parameters:
- PC_WIDTH, 32, width of PC and instruction-memory address.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- imem_req  out  1  fetch request for imem_addr.
- imem_addr  out  PC_WIDTH  current PC, word-aligned.
- imem_ready  in  1  imem_rdata is valid for the current imem_addr this cycle.
- imem_rdata  in  32  instruction word.
- stall  in  1  hazard hold: keep IF/ID and PC unchanged.
- flush  in  1  squash the instruction in IF/ID.
- redirect  in  1  branch/jump taken.
- redirect_pc  in  PC_WIDTH  new PC on redirect.
- id_valid  out  1  IF/ID holds a real instruction.
- id_instr  out  32  registered instruction, 0 when id_valid=0.
- id_pc4  out  PC_WIDTH  PC+4 of the id_instr.
- id_opcode  out  6  id_instr[31:26].
- id_rs  out  5  id_instr[25:21].
- id_rt  out  5  id_instr[20:16].
- id_rd  out  5  id_instr[15:11].
- id_imm  out  16  id_instr[15:0].

Behaviour:
- Reset state: pc=RESET_PC, state=FETCH, buffer empty, id_valid=0, id_instr=0, id_pc4=0. imem_req=0 in any cycle where rst=1.
- Memory model:
  - imem_addr is combinational from pc.
  - imem_ready in a cycle means the data belongs to that cycle's address.
  - Abandoning a request (redirect, reset) needs no cancel handshake.
- Outputs:
  - imem_req = (state==FETCH) && !rst.
  - id_opcode, id_rs, id_rt, id_rd and id_imm are pure slices of id_instr.
- State FETCH:
  - imem_ready=1, stall=0: IF/ID <= {valid=1, instr=imem_rdata, pc4=pc+4}; pc <= pc+4; stay in FETCH.
  - imem_ready=1, stall=1: buffer <= {imem_rdata, pc+4}; pc <= pc+4; IF/ID unchanged; go to HOLD.
  - imem_ready=0, stall=0: IF/ID <= bubble (valid=0, instr=0, pc4=0); pc unchanged.
  - imem_ready=0, stall=1: everything unchanged.
- State HOLD:
  - imem_req=0; pc unchanged.
  - When stall=0: IF/ID <= buffer with valid=1; buffer cleared; go to FETCH.
  - When stall=1: stay in HOLD.
- Priority, highest first: rst > redirect > flush > stall.
  - redirect (any state): pc <= redirect_pc; buffer dropped; any same-cycle imem response discarded; IF/ID <= bubble; state <= FETCH. First request to redirect_pc is issued the next cycle.
  - flush without redirect: IF/ID <= bubble even if stall=1. Fetch/HOLD progress proceeds as if stall=0, so no fetched instruction is lost.
- Latency: rst deasserted at cycle N with imem_ready=1 gives id_valid=1 with the RESET_PC instruction at N+1. Steady state is one instruction per cycle.
- Arithmetic: pc+4 is modulo 2^PC_WIDTH, so 0xFFFFFFFC wraps to 0x0. The low two bits of redirect_pc are forced to 0.
- rst mid-operation (HOLD or pending FETCH): immediate return to reset state; buffered instruction discarded.
- No instruction is duplicated or dropped across any stall/release sequence.

Test Plan:
- Sequential fetch: rst 2 cycles, imem_ready=1, ROM[a]=a|0x20000000.
  - Consecutive cycles show id_instr 0x20000000, 0x20000004, 0x20000008.
  - id_pc4 reads 4, 8, 12; imem_addr steps 0, 4, 8, 12.
- Memory wait: imem_ready=0 for 3 cycles at pc=0x8.
  - imem_addr holds 0x8; id_valid=0 and id_instr=0 for 3 cycles.
  - Instruction at 0x8 appears on the cycle after ready rises.
- Stall capture: stall=1 in the same cycle ROM returns the word at 0x10.
  - IF/ID keeps the word at 0xC; imem_req=0 while stalled.
  - Release gives id_instr = word at 0x10, id_pc4=0x14; next imem_addr=0x14.
- Redirect+flush: redirect=1, flush=1, redirect_pc=0x43, imem_ready=1 at pc=0x20.
  - Next cycle: id_valid=0, imem_addr=0x40; the word at 0x20 never appears in ID.
- Flush during stall: stall=1, flush=1 with a valid instruction in ID.
  - Next cycle id_valid=0, id_instr=0.
  - Buffered/returned instruction appears following cycle, none lost.
- Reset mid-HOLD plus wrap:
  - rst during HOLD: id_valid=0, imem_addr=RESET_PC, buffer empty.
  - Separately, redirect_pc=0xFFFFFFFC: fetch there, then imem_addr=0x0 and id_pc4=0x0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with a one-entry stall buffer and the IF/ID pipeline register.
// An empty IF/ID slot is presented as an all-zero instruction.
module fetch_stage #(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ready,
    input  logic [31:0]         imem_rdata,
    input  logic                stall,
    input  logic                flush,
    input  logic                redirect,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic                id_valid,
    output logic [31:0]         id_instr,
    output logic [PC_WIDTH-1:0] id_pc4,
    output logic [5:0]          id_opcode,
    output logic [4:0]          id_rs,
    output logic [4:0]          id_rt,
    output logic [4:0]          id_rd,
    output logic [15:0]         id_imm
);

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t              state_q;
    logic [PC_WIDTH-1:0] pc_q;
    logic [31:0]         buf_instr_q;
    logic [PC_WIDTH-1:0] buf_pc4_q;
    logic                id_valid_q;
    logic [31:0]         id_instr_q;
    logic [PC_WIDTH-1:0] id_pc4_q;

    logic [PC_WIDTH-1:0] pc_plus4_s;
    logic [PC_WIDTH-1:0] redirect_aligned_s;

    assign pc_plus4_s         = pc_q + PC_WIDTH'(32'd4);
    assign redirect_aligned_s = redirect_pc & {{(PC_WIDTH-2){1'b1}}, 2'b00};

    assign imem_req  = (state_q == FETCH) && !rst;
    assign imem_addr = pc_q;

    assign id_valid  = id_valid_q;
    assign id_instr  = id_instr_q;
    assign id_pc4    = id_pc4_q;
    assign id_opcode = id_instr_q[31:26];
    assign id_rs     = id_instr_q[25:21];
    assign id_rt     = id_instr_q[20:16];
    assign id_rd     = id_instr_q[15:11];
    assign id_imm    = id_instr_q[15:0];

    // PC, stall buffer and IF/ID update; priority is rst > redirect > flush > stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            buf_instr_q <= 32'h0000_0000;
            buf_pc4_q   <= '0;
            id_valid_q  <= 1'b0;
            id_instr_q  <= 32'h0000_0000;
            id_pc4_q    <= '0;
        end else if (redirect) begin
            state_q     <= FETCH;
            pc_q        <= redirect_aligned_s;
            buf_instr_q <= 32'h0000_0000;
            buf_pc4_q   <= '0;
            id_valid_q  <= 1'b0;
            id_instr_q  <= 32'h0000_0000;
            id_pc4_q    <= '0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (imem_ready) begin
                        pc_q <= pc_plus4_s;
                        // A flushed slot cannot take the new word, so it is parked like a stall.
                        if (stall || flush) begin
                            buf_instr_q <= imem_rdata;
                            buf_pc4_q   <= pc_plus4_s;
                            state_q     <= HOLD;
                            if (flush) begin
                                id_valid_q <= 1'b0;
                                id_instr_q <= 32'h0000_0000;
                                id_pc4_q   <= '0;
                            end
                        end else begin
                            id_valid_q <= 1'b1;
                            id_instr_q <= imem_rdata;
                            id_pc4_q   <= pc_plus4_s;
                        end
                    end else if (!stall || flush) begin
                        id_valid_q <= 1'b0;
                        id_instr_q <= 32'h0000_0000;
                        id_pc4_q   <= '0;
                    end
                end
                HOLD: begin
                    if (flush) begin
                        id_valid_q <= 1'b0;
                        id_instr_q <= 32'h0000_0000;
                        id_pc4_q   <= '0;
                    end else if (!stall) begin
                        id_valid_q  <= 1'b1;
                        id_instr_q  <= buf_instr_q;
                        id_pc4_q    <= buf_pc4_q;
                        buf_instr_q <= 32'h0000_0000;
                        buf_pc4_q   <= '0;
                        state_q     <= FETCH;
                    end
                end
                default: begin
                    state_q <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed test-plan sequence with literal expectations, then
// randomized traffic, all outputs compared every cycle against a queue-based reference model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst, imem_ready, stall, flush, redirect;
    logic [31:0] redirect_pc;
    logic        imem_req, id_valid;
    logic [31:0] imem_addr, imem_rdata, id_instr, id_pc4;
    logic [5:0]  id_opcode;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [15:0] id_imm;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return a | 32'h2000_0000;
    endfunction

    assign imem_rdata = rom(imem_addr);

    fetch_stage #(.PC_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .stall(stall),
        .flush(flush), .redirect(redirect), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc4(id_pc4),
        .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_imm(id_imm)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: words that could not enter ID wait in a queue; ID is a plain record.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } slot_t;

    slot_t       parked[$];
    logic [31:0] m_pc     = 32'h0;
    logic        m_valid  = 1'b0;
    slot_t       m_id     = '0;
    bit          started  = 1'b0;

    always @(posedge clk) begin
        slot_t word;
        started = 1'b1;
        if (rst) begin
            m_pc = 32'h0;
            parked.delete();
            m_valid = 1'b0; m_id = '0;
        end else if (redirect) begin
            m_pc = {redirect_pc[31:2], 2'b00};
            parked.delete();
            m_valid = 1'b0; m_id = '0;
        end else if (parked.size() != 0) begin
            if (flush) begin
                m_valid = 1'b0; m_id = '0;
            end else if (!stall) begin
                m_id = parked.pop_front();
                m_valid = 1'b1;
            end
        end else if (imem_ready) begin
            word.instr = rom(m_pc);
            word.pc4   = m_pc + 32'd4;
            m_pc       = m_pc + 32'd4;
            if (stall || flush) begin
                parked.push_back(word);
                if (flush) begin
                    m_valid = 1'b0; m_id = '0;
                end
            end else begin
                m_id = word; m_valid = 1'b1;
            end
        end else if (!stall || flush) begin
            m_valid = 1'b0; m_id = '0;
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            chk("imem_req",  {63'h0, imem_req}, {63'h0, (!rst && parked.size() == 0)});
            chk("imem_addr", {32'h0, imem_addr}, {32'h0, m_pc});
            chk("id_valid",  {63'h0, id_valid}, {63'h0, m_valid});
            chk("id_instr",  {32'h0, id_instr}, {32'h0, m_id.instr});
            chk("id_pc4",    {32'h0, id_pc4},   {32'h0, m_id.pc4});
            chk("id_fields", {27'h0, id_opcode, id_rs, id_rt, id_rd, id_imm},
                {27'h0, m_id.instr[31:11], m_id.instr[15:0]});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic lit(input string name, input logic v, input logic [31:0] ins,
                       input logic [31:0] pc4, input logic [31:0] addr);
        chk({name, ".valid"}, {63'h0, id_valid}, {63'h0, v});
        chk({name, ".instr"}, {32'h0, id_instr}, {32'h0, ins});
        chk({name, ".pc4"},   {32'h0, id_pc4},   {32'h0, pc4});
        chk({name, ".addr"},  {32'h0, imem_addr}, {32'h0, addr});
    endtask

    initial begin
        rst = 1'b1; imem_ready = 1'b1; stall = 1'b0; flush = 1'b0;
        redirect = 1'b0; redirect_pc = 32'h0;
        cyc(); cyc();
        lit("reset", 1'b0, 32'h0, 32'h0, 32'h0);
        chk("reset.req", {63'h0, imem_req}, 64'h0);

        rst = 1'b0;
        cyc(); lit("seq0", 1'b1, 32'h2000_0000, 32'h4, 32'h4);
        cyc(); lit("seq1", 1'b1, 32'h2000_0004, 32'h8, 32'h8);

        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(); lit("wait", 1'b0, 32'h0, 32'h0, 32'h8);
        end
        imem_ready = 1'b1;
        cyc(); lit("seq2", 1'b1, 32'h2000_0008, 32'hC, 32'hC);
        cyc(); lit("seq3", 1'b1, 32'h2000_000C, 32'h10, 32'h10);

        stall = 1'b1;
        cyc(); lit("stall", 1'b1, 32'h2000_000C, 32'h10, 32'h14);
        chk("stall.req", {63'h0, imem_req}, 64'h0);
        stall = 1'b0;
        cyc(); lit("release", 1'b1, 32'h2000_0010, 32'h14, 32'h14);
        cyc(); cyc(); cyc();
        lit("seq7", 1'b1, 32'h2000_001C, 32'h20, 32'h20);

        redirect = 1'b1; flush = 1'b1; redirect_pc = 32'h43;
        cyc(); lit("redir", 1'b0, 32'h0, 32'h0, 32'h40);
        redirect = 1'b0; flush = 1'b0;
        cyc(); lit("redir_tgt", 1'b1, 32'h2000_0040, 32'h44, 32'h44);

        stall = 1'b1; flush = 1'b1;
        cyc(); lit("flush_stall", 1'b0, 32'h0, 32'h0, 32'h48);
        stall = 1'b0; flush = 1'b0;
        cyc(); lit("flush_rel", 1'b1, 32'h2000_0044, 32'h48, 32'h48);

        stall = 1'b1;
        cyc(); lit("hold", 1'b1, 32'h2000_0044, 32'h48, 32'h4C);
        rst = 1'b1;
        cyc(); lit("rst_hold", 1'b0, 32'h0, 32'h0, 32'h0);
        rst = 1'b0; stall = 1'b0;
        cyc(); lit("post_rst", 1'b1, 32'h2000_0000, 32'h4, 32'h4);

        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        cyc(); lit("wrap_redir", 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFC);
        redirect = 1'b0;
        cyc(); lit("wrap", 1'b1, 32'hFFFF_FFFC, 32'h0, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 49) == 0);
            redirect    = ($urandom_range(0, 9) == 0);
            flush       = ($urandom_range(0, 7) == 0);
            stall       = ($urandom_range(0, 3) == 0);
            imem_ready  = ($urandom_range(0, 3) != 0);
            redirect_pc = $urandom();
            cyc();
        end
        rst = 1'b0; redirect = 1'b0; flush = 1'b0; stall = 1'b0;
        cyc(); cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
